// File: rtl/uart_tx_top.sv
// UART transmitter: start bit, DATA_WIDTH data bits (LSB first), optional
// parity bit, one stop bit. Each bit lasts prescale clk cycles (0 -> 2^PRESCALE_WIDTH).
//
// Handshake: a request is data_valid=1 sampled on a clk edge while busy=0.
// On that edge p_data and the frame settings are latched, busy rises and the
// start bit appears on tx_out. While busy=1, data_valid is ignored and is not
// queued. busy falls on the edge that ends the stop bit.
module uart_tx_top #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]                state;
  logic [DATA_WIDTH-1:0]     data_r;
  logic                      par_en_r;
  logic                      par_typ_r;
  logic [PRESCALE_WIDTH-1:0] prescale_r;
  logic [PRESCALE_WIDTH-1:0] timer;
  logic [IDX_W-1:0]          bit_idx;

  logic [PRESCALE_WIDTH-1:0] last_tick;
  logic [IDX_W-1:0]          next_idx;
  logic                      bit_end;
  logic                      last_data_bit;
  logic                      parity_bit;

  // Bit boundary: the timer wraps modulo 2^PRESCALE_WIDTH, so prescale=0
  // makes last_tick all-ones and the bit lasts the full counter range.
  assign last_tick     = prescale_r - {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
  assign bit_end       = (timer == last_tick);
  assign next_idx      = bit_idx + {{(IDX_W-1){1'b0}}, 1'b1};
  assign last_data_bit = (bit_idx == IDX_W'(DATA_WIDTH - 1));
  assign parity_bit    = (^data_r) ^ par_typ_r;

  // Frame sequencer; tx_out and busy are registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      data_r     <= '0;
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      prescale_r <= '0;
      timer      <= '0;
      bit_idx    <= '0;
    end else begin
      if (state != IDLE) begin
        timer <= bit_end ? '0 : timer + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
      end
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          if (data_valid) begin
            data_r     <= p_data;
            par_en_r   <= par_en;
            par_typ_r  <= par_typ;
            prescale_r <= prescale;
            timer      <= '0;
            bit_idx    <= '0;
            state      <= START;
            tx_out     <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx_out  <= data_r[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (last_data_bit) begin
              if (par_en_r) begin
                state  <= PARITY;
                tx_out <= parity_bit;
              end else begin
                state  <= STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_idx <= next_idx;
              tx_out  <= data_r[next_idx];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state  <= STOP;
            tx_out <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state  <= IDLE;
            busy   <= 1'b0;
            tx_out <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: table-driven frames, hand-written corner sequences
// (back-to-back, mid-frame reset) and randomized frames against a bit-list model.
module tb_uart_tx_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [4:0] prescale;
  logic       tx_out;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [0:0] exp_q[$];
  logic [0:0] cap_q[$];

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic [4:0] ps;
    int         exp_len;
    int         exp_par;   // 2 = no parity bit in the frame
  } vec_t;

  vec_t vecs[6];

  uart_tx_top #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the frame as a list of line levels, one per bit period.
  function automatic void build_model(input logic [7:0] d, input logic pe, input logic pt);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back(1'((($countones(d) % 2) == 1) ^ pt));
    exp_q.push_back(1'b1);
  endfunction

  function automatic int period(input logic [4:0] ps);
    return (ps == 5'd0) ? 32 : int'(ps);
  endfunction

  // driver: present a request; returns at the negedge after the accepting posedge
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] ps);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = ps;
    data_valid = 1'b1;
    @(negedge clk);
  endtask

  // capture the busy window and compare it bit by bit with the model
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input logic [4:0] ps, input bit keep, input bit scramble,
                           input logic [7:0] next_d, input string name);
    int p;
    logic [31:0] act;
    p = period(ps);
    build_model(d, pe, pt);
    cap_q.delete();
    for (int c = 0; c < 400; c++) begin
      if (busy !== 1'b1) break;
      cap_q.push_back(tx_out);
      if (keep) begin
        data_valid = 1'b1;
        p_data     = next_d;
      end else if (scramble) begin
        data_valid = 1'($urandom_range(0, 1));
        p_data     = 8'($urandom_range(0, 255));
        par_en     = 1'($urandom_range(0, 1));
        par_typ    = 1'($urandom_range(0, 1));
        prescale   = 5'($urandom_range(0, 31));
      end else begin
        data_valid = 1'b0;
      end
      @(negedge clk);
    end
    if (!keep) data_valid = 1'b0;
    check({name, " len"}, 32'(cap_q.size()), 32'(exp_q.size() * p));
    for (int i = 0; i < exp_q.size(); i++) begin
      act = {31'b0, exp_q[i]};
      for (int j = 0; j < p; j++) begin
        if (i * p + j >= cap_q.size()) begin
          act = 32'd2;
          break;
        end
        if (cap_q[i * p + j] !== exp_q[i]) begin
          act = {31'b0, cap_q[i * p + j]};
          break;
        end
      end
      check($sformatf("%s bit%0d", name, i), act, {31'b0, exp_q[i]});
    end
    check({name, " idle tx"}, {31'b0, tx_out}, 32'd1);
    check({name, " idle busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int seen;
    int p;
    logic [31:0] act;

    vecs[0] = '{d: 8'hA5, pe: 1'b0, pt: 1'b0, ps: 5'd8,  exp_len: 80,  exp_par: 2};
    vecs[1] = '{d: 8'h07, pe: 1'b1, pt: 1'b0, ps: 5'd16, exp_len: 176, exp_par: 1};
    vecs[2] = '{d: 8'h07, pe: 1'b1, pt: 1'b1, ps: 5'd16, exp_len: 176, exp_par: 0};
    vecs[3] = '{d: 8'hFF, pe: 1'b0, pt: 1'b0, ps: 5'd0,  exp_len: 320, exp_par: 2};
    vecs[4] = '{d: 8'h00, pe: 1'b1, pt: 1'b1, ps: 5'd1,  exp_len: 11,  exp_par: 1};
    vecs[5] = '{d: 8'h80, pe: 1'b1, pt: 1'b0, ps: 5'd3,  exp_len: 33,  exp_par: 1};

    rst        = 1'b1;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 5'd8;
    repeat (3) @(negedge clk);
    check("reset tx", {31'b0, tx_out}, 32'd1);
    check("reset busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // table-driven frames
    foreach (vecs[k]) begin
      send(vecs[k].d, vecs[k].pe, vecs[k].pt, vecs[k].ps);
      run_frame(vecs[k].d, vecs[k].pe, vecs[k].pt, vecs[k].ps, 1'b0, 1'b0, 8'h00,
                $sformatf("vec%0d", k));
      check($sformatf("vec%0d table len", k), 32'(cap_q.size()), 32'(vecs[k].exp_len));
      if (vecs[k].exp_par != 2) begin
        p   = period(vecs[k].ps);
        act = (cap_q.size() > 9 * p) ? {31'b0, cap_q[9 * p]} : 32'd2;
        check($sformatf("vec%0d parity", k), act, 32'(vecs[k].exp_par));
      end
      repeat (2) @(negedge clk);
    end

    // back-to-back with data_valid held high; p_data changes mid-frame
    send(8'h3C, 1'b0, 1'b0, 5'd8);
    run_frame(8'h3C, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 8'hC3, "b2b first");
    @(negedge clk);
    check("b2b gap one cycle", {31'b0, busy}, 32'd1);
    run_frame(8'hC3, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1, 8'h00, "b2b second");
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy !== 1'b0) seen++;
      @(negedge clk);
    end
    check("b2b no third frame", 32'(seen), 32'd0);

    // reset in DATA bit 3
    send(8'hA5, 1'b0, 1'b0, 5'd8);
    data_valid = 1'b0;
    repeat (34) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset tx", {31'b0, tx_out}, 32'd1);
    check("midreset busy", {31'b0, busy}, 32'd0);
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy !== 1'b0 || tx_out !== 1'b1) seen++;
      @(negedge clk);
    end
    check("midreset no resume", 32'(seen), 32'd0);
    send(8'h5A, 1'b1, 1'b1, 5'd8);
    run_frame(8'h5A, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 8'h00, "after reset");

    // randomized frames, inputs scrambled and data_valid pulsed while busy
    for (int r = 0; r < 40; r++) begin
      logic [7:0] d;
      logic       pe;
      logic       pt;
      logic [4:0] ps;
      d  = 8'($urandom_range(0, 255));
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      ps = 5'($urandom_range(0, 12));
      send(d, pe, pt, ps);
      run_frame(d, pe, pt, ps, 1'b0, 1'b1, 8'h00, $sformatf("rand%0d", r));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
